div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Execute-stage controller for DIV/DIVU, sitting between the EX pipeline stage and the iterative divider.
- Accepts a divide op from EX, latches its operands, and drives the divider's start/annul/signed/operand inputs.
- Stalls the pipeline until the divider signals ready, then commits the divider's 64-bit result into the architectural HI/LO registers.
- Also owns HI/LO writes from MTHI/MTLO and exposes HI/LO to the read path.

Parameters:
DRAIN_CYCLES, 2, number of cycles div_start_o is held low after completion or flush before a new divide may start; must be >= 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
op_valid_i  in  1  EX holds a valid instruction this cycle
op_div_i  in  1  instruction is DIV (signed)
op_divu_i  in  1  instruction is DIVU (unsigned)
opdata1_i  in  32  dividend from EX
opdata2_i  in  32  divisor from EX
flush_i  in  1  pipeline flush (exception/redirect); kills the in-flight divide
hi_we_i  in  1  MTHI write enable
hi_i  in  32  MTHI data
lo_we_i  in  1  MTLO write enable
lo_i  in  32  MTLO data
div_result_i  in  64  divider result: [31:0] quotient, [63:32] remainder
div_ready_i  in  1  divider result valid
div_start_o  out  1  divider start; held high until ready observed
div_annul_o  out  1  divider annul
div_signed_o  out  1  1 = signed divide
div_op1_o  out  32  latched dividend
div_op2_o  out  32  latched divisor
stall_o  out  1  stall request to pipeline (combinational)
hi_o  out  32  HI register
lo_o  out  32  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE; hi_o=lo_o=0; div_op1_o=div_op2_o=0; div_signed_o=0; div_start_o=0; div_annul_o=0; drain counter=0. stall_o=0 while in reset.
- Accept condition: go = op_valid_i & (op_div_i | op_divu_i) & ~flush_i.
- If op_div_i and op_divu_i are both set, treat as signed.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - On go: latch opdata1_i/opdata2_i into div_op1_o/div_op2_o; set div_signed_o=op_div_i; go to BUSY.
  - stall_o=1 in the accept cycle.
- BUSY:
  - div_start_o=1 (decoded from state); div_annul_o=0.
  - stall_o = ~div_ready_i.
  - If flush_i: div_annul_o=1, div_start_o=0, stall_o=0; no HI/LO update; go to DRAIN. Flush has priority over div_ready_i in the same cycle.
  - Else if div_ready_i: at the clock edge write lo_o<=div_result_i[31:0] and hi_o<=div_result_i[63:32]; go to DRAIN.
- DRAIN:
  - div_start_o=0; lasts DRAIN_CYCLES cycles, counted by the drain counter, then go to IDLE.
  - A go request arriving in DRAIN is not accepted; stall_o=1 for it and it is accepted in the following IDLE cycle.
  - stall_o=0 when there is no divide request.
- Divider handshake (fixed):
  - start must stay high until ready is seen.
  - Ready stays high while start stays high.
  - The divider only returns to free after start is low for at least one cycle, two if the divisor was 0.
  - DRAIN exists so a back-to-back divide never sees stale ready.
- Divide by zero: the divider returns result 0, so HI=LO=0; no trap.
- HI/LO write priority, same edge: divide capture > hi_we_i/lo_we_i. MTHI/MTLO writes are otherwise applied in any state, independently of each other.
- Flush in IDLE or DRAIN: no effect on state; kills any same-cycle go.
- Reset mid-divide: immediate return to IDLE with outputs at reset values. The divider is reset by the same rst.

Test Plan:
- DIV 100 / 7 (signed, real divider): stall_o high 36 consecutive cycles from accept → lo_o=14, hi_o=2; DRAIN lasts 2 cycles.
- DIV 0xFFFFFFF9 (-7) / 2: → lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1). DIVU of the same operands: → lo_o=0x7FFFFFFC, hi_o=1.
- DIVU 5 / 0: stall_o high 4 cycles → hi_o=lo_o=0; next divide 9/3 is accepted after DRAIN and yields lo_o=3, hi_o=0.
- Back-to-back: second DIV asserted the cycle after the first completes → stall_o held through DRAIN; second result correct, with no capture of stale ready.
- flush_i in BUSY cycle 10 → div_annul_o pulses 1 cycle, stall_o=0, HI/LO unchanged (preloaded 0xAAAA_AAAA / 0x5555_5555 via MTHI/MTLO).
- MTHI 0x1234 on the same edge as a divide capture → hi_o takes the remainder. rst asserted mid-BUSY → all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - EX-stage DIV/DIVU controller: divider handshake, pipeline stall, HI/LO registers
module div_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic        op_div_i,
    input  logic        op_divu_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        flush_i,
    input  logic        hi_we_i,
    input  logic [31:0] hi_i,
    input  logic        lo_we_i,
    input  logic [31:0] lo_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_drain;
    logic          r_signed;
    logic [31:0]   r_op1;
    logic [31:0]   r_op2;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic          w_go;
    logic          w_capture;
    logic          w_stall;

    assign w_go      = op_valid_i & (op_div_i | op_divu_i) & ~flush_i;
    // A flush in the ready cycle wins: the result is dropped.
    assign w_capture = (r_state == S_BUSY) & ~flush_i & div_ready_i;

    // Start is held for the whole BUSY phase; a flush turns it into a one-cycle annul.
    assign div_start_o  = (r_state == S_BUSY) & ~flush_i;
    assign div_annul_o  = (r_state == S_BUSY) & flush_i;
    assign div_signed_o = r_signed;
    assign div_op1_o    = r_op1;
    assign div_op2_o    = r_op2;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;
    assign stall_o      = w_stall;

    // Stall: hold a pending divide in IDLE/DRAIN, hold the pipe in BUSY until ready.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = w_go;
            S_BUSY:  w_stall = ~flush_i & ~div_ready_i;
            S_DRAIN: w_stall = w_go;
            default: w_stall = 1'b0;
        endcase
        if (rst) begin
            w_stall = 1'b0;
        end
    end

    // Control FSM: accept and latch operands, wait for ready or flush, then drain so the
    // divider drops its ready before the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_drain  <= '0;
            r_signed <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_op1    <= opdata1_i;
                        r_op2    <= opdata2_i;
                        r_signed <= op_div_i;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush_i || div_ready_i) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == CW'(DRAIN_CYCLES - 1)) begin
                        r_drain <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // HI/LO: divide capture overrides MTHI/MTLO on the same edge; otherwise each is independent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_capture) begin
            r_hi <= div_result_i[63:32];
            r_lo <= div_result_i[31:0];
        end else begin
            if (hi_we_i) begin
                r_hi <= hi_i;
            end
            if (lo_we_i) begin
                r_lo <= lo_i;
            end
        end
    end

endmodule
